vmem_port_arbiter: RTL

Round-robin arbiter that shares one 1R1W abstract memory port between NREQ register-file processor cores (LOAD/STORE traffic).
- Sits between the cores' `mem_r_*`/`mem_w_*` channels and the memory model, so several cores can be checked against one shared memory.
- Grants one access per cycle, returns read data after one cycle tagged to the requester, and supports a bounded lock for atomic multi-beat sequences.

---
 rtl/vmem_arb_pkg.sv | 17 +
 rtl/vmem_port_arbiter_if.sv | 35 +++
 rtl/rr_pick.sv | 33 +++
 rtl/vmem_port_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/vmem_arb_pkg.sv
// Shared types, default widths and the round-robin helper for the memory port arbiter.
package vmem_arb_pkg;

   typedef enum logic [0:0] {
      IDLE,
      LOCKED
   } state_e;

   localparam int unsigned DefaultAw = 8;
   localparam int unsigned DefaultDw = 8;

   // Next requester index after idx, wrapping at nreq.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
      return (idx + 1 >= nreq) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/vmem_port_arbiter_if.sv
// Bundle of requester handshake, response and memory-port signals around the arbiter.
interface vmem_port_arbiter_if #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = 8,
   parameter int unsigned DW   = 8
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_we;
   logic [NREQ-1:0]    req_lock;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_data;
   logic               mem_ren;
   logic               mem_wen;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;
   logic [DW-1:0]      mem_rdata;
   logic               lock_abort;

   // Requesters plus memory model side.
   modport master (
      output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_data, mem_ren, mem_wen, mem_addr, mem_wdata,
             lock_abort
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_data, mem_ren, mem_wen, mem_addr, mem_wdata,
             lock_abort
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first valid requester at or after ptr wins.
module rr_pick #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IW   = 1
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   // Walk ptr, ptr+1, ... modulo NREQ and take the first valid one.
   always_comb begin
      int unsigned j;
      j     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j = 32'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!any && (i == j) && valid[i]) begin
               any      = 1'b1;
               grant[i] = 1'b1;
               idx      = IW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/vmem_port_arbiter.sv
// Round-robin arbiter sharing one 1R1W memory port between NREQ requesters, with bounded lock.
module vmem_port_arbiter
   import vmem_arb_pkg::*;
#(
   parameter int unsigned AW       = DefaultAw,
   parameter int unsigned DW       = DefaultDw,
   parameter int unsigned NREQ     = 2,
   parameter int unsigned LOCK_MAX = 15
) (
   input logic              clk,
   input logic              rst,
   vmem_port_arbiter_if.slave bus
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(LOCK_MAX + 1);

   state_e          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] rsp_q, rsp_d;

   logic [NREQ-1:0] pick_grant;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;

   logic [NREQ-1:0] ready;
   logic            beat;
   logic [IW-1:0]   beat_idx;
   logic            beat_we;
   logic            beat_lock;
   logic [AW-1:0]   addr_mux;
   logic [DW-1:0]   wdata_mux;
   logic            abort;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .valid (bus.req_valid),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Ready: round-robin winner in IDLE, owner only (even when idle) in LOCKED, none in reset.
   always_comb begin
      ready = '0;
      if (!rst) begin
         if (state_q == IDLE) begin
            ready = pick_any ? pick_grant : '0;
         end else begin
            ready[owner_q] = 1'b1;
         end
      end
   end

   // Accepted beat decode and memory-port data mux; port is zeroed when no beat.
   always_comb begin
      beat      = 1'b0;
      beat_idx  = '0;
      beat_we   = 1'b0;
      beat_lock = 1'b0;
      addr_mux  = '0;
      wdata_mux = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (ready[i] && bus.req_valid[i]) begin
            beat      = 1'b1;
            beat_idx  = IW'(i);
            beat_we   = bus.req_we[i];
            beat_lock = bus.req_lock[i];
            addr_mux  = bus.req_addr[i*AW +: AW];
            wdata_mux = bus.req_wdata[i*DW +: DW];
         end
      end
   end

   // Next-state logic for FSM, pointer, owner and lock counter.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      abort   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (beat) begin
               ptr_d = IW'(rr_next(32'(beat_idx), NREQ));
               if (beat_lock) begin
                  state_d = LOCKED;
                  owner_d = beat_idx;
                  cnt_d   = CW'(1);
               end
            end
         end
         LOCKED: begin
            if (cnt_q == CW'(LOCK_MAX)) begin
               // Forced release; an owner beat this cycle still goes through but cannot relock.
               abort   = 1'b1;
               state_d = IDLE;
               ptr_d   = IW'(rr_next(32'(owner_q), NREQ));
               cnt_d   = '0;
            end else if (beat && !beat_lock) begin
               state_d = IDLE;
               ptr_d   = IW'(rr_next(32'(owner_q), NREQ));
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Response tag: one-hot of the read accepted this cycle.
   always_comb begin
      rsp_d = ready & bus.req_valid & ~bus.req_we;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         rsp_q   <= rsp_d;
      end
   end

   // Output drive; a response in flight is masked while reset is held.
   always_comb begin
      bus.req_ready  = ready;
      bus.mem_wen    = beat & beat_we;
      bus.mem_ren    = beat & ~beat_we;
      bus.mem_addr   = addr_mux;
      bus.mem_wdata  = wdata_mux;
      bus.rsp_valid  = rst ? '0 : rsp_q;
      bus.rsp_data   = bus.mem_rdata;
      bus.lock_abort = abort & ~rst;
   end

endmodule
